// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit for the EX stage: launches an op, holds busy for a fixed
// latency, then commits the precomputed 64-bit result into HI/LO.
module mul_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

   state_t         state_r, state_nxt_s;
   logic [CW-1:0]  cnt_r, cnt_nxt_s, load_s;
   logic [63:0]    res_r, res_s;
   logic           wr_r, wr_s;
   logic [31:0]    hi_r, lo_r;
   logic           is_md_s, is_div_s, done_s, start_s, idle_s;
   logic signed [63:0] sa_s, sb_s;
   logic [31:0]    abs_a_s, abs_b_s, q_mag_s, r_mag_s, b_nz_s;

   assign idle_s   = (state_r == ST_IDLE);
   assign is_md_s  = (op >= OP_MULT) && (op <= OP_DIVU);
   assign is_div_s = (op == OP_DIV) || (op == OP_DIVU);
   assign done_s   = (state_r == ST_BUSY) && (cnt_r == CW'(1));
   assign load_s   = is_div_s ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

   // Operand conditioning; divisor forced nonzero so a /0 never reaches the divider.
   assign sa_s    = {{32{a[31]}}, a};
   assign sb_s    = {{32{b[31]}}, b};
   assign abs_a_s = a[31] ? (32'd0 - a) : a;
   assign abs_b_s = b[31] ? (32'd0 - b) : b;
   assign b_nz_s  = (b == 32'd0) ? 32'd1 : b;
   assign q_mag_s = abs_a_s / ((abs_b_s == 32'd0) ? 32'd1 : abs_b_s);
   assign r_mag_s = abs_a_s % ((abs_b_s == 32'd0) ? 32'd1 : abs_b_s);

   // Result computed at launch; signed divide via magnitudes covers 0x80000000 / -1.
   always_comb begin
      res_s = 64'd0;
      wr_s  = !(is_div_s && (b == 32'd0));
      case (op)
         OP_MULT:  res_s = sa_s * sb_s;
         OP_MULTU: res_s = {32'd0, a} * {32'd0, b};
         OP_DIV:   res_s = {(a[31] ? (32'd0 - r_mag_s) : r_mag_s),
                            ((a[31] ^ b[31]) ? (32'd0 - q_mag_s) : q_mag_s)};
         OP_DIVU:  res_s = {a % b_nz_s, a / b_nz_s};
         default:  res_s = 64'd0;
      endcase
   end

   // State and latency counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state: load latency on launch, count down, return to idle on the last cycle.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_nxt_s = ST_BUSY;
               cnt_nxt_s   = load_s;
            end else begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = '0;
            end
         end
         ST_BUSY: begin
            if (done_s) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = ST_BUSY;
               cnt_nxt_s   = cnt_r - CW'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // Outputs: launch strobe and mfhi/mflo read mux.
   always_comb begin
      start_s = en && idle_s && is_md_s;
      case (op)
         OP_MFHI: rd = hi_r;
         OP_MFLO: rd = lo_r;
         default: rd = 32'd0;
      endcase
   end

   // HI/LO and pending result; move-to writes only land while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r  <= 32'd0;
         lo_r  <= 32'd0;
         res_r <= 64'd0;
         wr_r  <= 1'b0;
      end else begin
         if (start_s) begin
            res_r <= res_s;
            wr_r  <= wr_s;
         end
         if (done_s && wr_r) begin
            hi_r <= res_r[63:32];
            lo_r <= res_r[31:0];
         end else if (en && idle_s && (op == OP_MTHI)) begin
            hi_r <= a;
         end else if (en && idle_s && (op == OP_MTLO)) begin
            lo_r <= a;
         end
      end
   end

   assign start = start_s;
   assign busy  = (state_r == ST_BUSY);
   assign hi    = hi_r;
   assign lo    = lo_r;

   mul_div_unit_chk u_chk (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .busy  (busy)
   );
endmodule

// Flags an op presented while busy; the hazard unit is expected to prevent it.
module mul_div_unit_chk (
   input logic clk,
   input logic reset,
   input logic en,
   input logic busy
);
   a_no_en_while_busy: assert property (@(posedge clk) disable iff (reset) !(en && busy))
      else $warning("mul_div_unit: en asserted while busy, op ignored");
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed HI/LO results, busy latency, reset abort.
module tb_mul_div_unit;
   logic        clk, reset, en;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        start, busy;
   logic [31:0] hi, lo, rd;
   int          errors = 0;
   int          checks = 0;

   mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .en(en), .op(op), .a(a), .b(b),
      .start(start), .busy(busy), .hi(hi), .lo(lo), .rd(rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch an op, scramble operands during busy, and measure the busy length.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int cycles);
      int n;
      en = 1'b1; op = o; a = x; b = y;
      #1;
      check({tag, "_start"}, start, 1);
      tick();
      en = 1'b0; op = 4'd0; a = 32'hA5A5_5A5A; b = 32'h0000_0003;
      n = 0;
      while (busy && n < 50) begin
         n++;
         tick();
      end
      check({tag, "_busy_cycles"}, n, cycles);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
      tick(); tick();
      reset = 1'b0;
      op = 4'd7;
      #1;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_rd", rd, 0);

      run_op("mult", 4'd1, 32'hFFFF_FFFD, 32'd5, 5);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      check("mult_lo", lo, 32'hFFFF_FFF1);

      run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 5);
      check("multu_hi", hi, 32'h0000_0001);
      check("multu_lo", lo, 32'hFFFF_FFFE);
      en = 1'b1; op = 4'd8;
      #1;
      check("mflo_rd", rd, 32'hFFFF_FFFE);
      check("mflo_nostart", start, 0);
      op = 4'd7;
      #1;
      check("mfhi_rd", rd, 32'h0000_0001);
      en = 1'b0;

      // Divide immediately after busy falls, then a divide by zero back to back.
      run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
      check("div_hi", hi, 32'hFFFF_FFFF);
      check("div_lo", lo, 32'hFFFF_FFFD);
      run_op("divu0", 4'd4, 32'd7, 32'd0, 10);
      check("divu0_hi", hi, 32'hFFFF_FFFF);
      check("divu0_lo", lo, 32'hFFFF_FFFD);

      run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      check("divovf_hi", hi, 32'd0);
      check("divovf_lo", lo, 32'h8000_0000);
      run_op("divu", 4'd4, 32'd100, 32'd7, 10);
      check("divu_hi", hi, 32'd2);
      check("divu_lo", lo, 32'd14);

      // mtlo presented mid-mult must be dropped.
      en = 1'b1; op = 4'd1; a = 32'd3; b = 32'd4;
      tick();
      en = 1'b1; op = 4'd6; a = 32'hDEAD_BEEF;
      #1;
      check("mtlo_busy_nostart", start, 0);
      tick();
      en = 1'b0; op = 4'd0;
      for (int i = 0; i < 20 && busy; i++) tick();
      check("mtlo_busy_hi", hi, 32'd0);
      check("mtlo_busy_lo", lo, 32'd12);

      en = 1'b1; op = 4'd5; a = 32'h1234_5678;
      tick();
      check("mthi_hi", hi, 32'h1234_5678);
      check("mthi_busy", busy, 0);
      op = 4'd6; a = 32'hCAFE_F00D;
      tick();
      check("mtlo_lo", lo, 32'hCAFE_F00D);
      check("mtlo_hi", hi, 32'h1234_5678);
      op = 4'd9; a = 32'h0BAD_0BAD;
      tick();
      check("op9_hi", hi, 32'h1234_5678);
      check("op9_lo", lo, 32'hCAFE_F00D);
      check("op9_busy", busy, 0);

      // Reset during the 4th busy cycle of a divide aborts it.
      en = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
      tick();
      en = 1'b0; op = 4'd0;
      check("abort_busy_on", busy, 1);
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_hi", hi, 0);
      check("abort_lo", lo, 0);
      for (int i = 0; i < 15; i++) tick();
      check("abort_late_hi", hi, 0);
      check("abort_late_lo", lo, 0);
      check("abort_late_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
